// File: rtl/water_level_sampler.sv
// Bottle water-level front end: samples a 15-probe thermometer sensor on a prescaled tick,
// rejects malformed codes, debounces to a stable 4-bit level and runs the interval timebase.
module water_level_sampler #(
   parameter int unsigned SAMPLE_DIV       = 1000,
   parameter int unsigned STABLE_N         = 4,
   parameter int unsigned INTERVAL_SAMPLES = 1800,
   parameter int unsigned COUNT_W          = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [14:0]        probe,
   output logic [3:0]         water_level,
   output logic               level_valid,
   output logic               probe_fault,
   output logic [COUNT_W-1:0] count,
   output logic               interval_start
);

   localparam int unsigned PresW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
   localparam int unsigned StabW = $clog2(STABLE_N + 1);
   localparam logic [PresW-1:0]   PresMax  = PresW'(SAMPLE_DIV - 1);
   localparam logic [StabW-1:0]   StabMax  = StabW'(STABLE_N);
   localparam logic [COUNT_W-1:0] CountMax = COUNT_W'(INTERVAL_SAMPLES - 1);

   logic [PresW-1:0]   presc_q, presc_d;
   logic [14:0]        sync1_q, sync2_q;
   logic [3:0]         cand_q, cand_d;
   logic [StabW-1:0]   stab_q, stab_d;
   logic [3:0]         level_q, level_d;
   logic               lv_q, lv_d;
   logic               fault_q, fault_d;
   logic [COUNT_W-1:0] count_q, count_d;
   logic               istart_q, istart_d;
   logic               tick, code_ok;
   logic [3:0]         samp_lvl;

   always_comb begin
      tick     = (presc_q == PresMax);
      presc_d  = tick ? '0 : presc_q + 1'b1;
      // 2**k-1 has no bit in common with its successor
      code_ok  = ((sync2_q & (sync2_q + 15'd1)) == 15'd0);
      samp_lvl = 4'd0;
      for (int i = 0; i < 15; i++) begin
         samp_lvl = samp_lvl + {3'b000, sync2_q[i]};
      end

      cand_d   = cand_q;
      stab_d   = stab_q;
      level_d  = level_q;
      lv_d     = 1'b0;
      fault_d  = 1'b0;
      count_d  = count_q;
      istart_d = 1'b0;

      if (tick) begin
         if (!code_ok) begin
            fault_d = 1'b1;
            stab_d  = '0;
         end else if (samp_lvl == cand_q) begin
            if (stab_q != StabMax) stab_d = stab_q + 1'b1;
         end else begin
            cand_d = samp_lvl;
            stab_d = StabW'(1);
         end

         if (code_ok && (stab_d == StabMax) && (cand_d != level_q)) begin
            level_d = cand_d;
            lv_d    = 1'b1;
         end

         if (count_q == CountMax) begin
            count_d  = '0;
            istart_d = 1'b1;
         end else begin
            count_d = count_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         presc_q  <= '0;
         sync1_q  <= '0;
         sync2_q  <= '0;
         cand_q   <= '0;
         stab_q   <= '0;
         level_q  <= '0;
         lv_q     <= 1'b0;
         fault_q  <= 1'b0;
         count_q  <= '0;
         istart_q <= 1'b0;
      end else begin
         presc_q  <= presc_d;
         sync1_q  <= probe;
         sync2_q  <= sync1_q;
         cand_q   <= cand_d;
         stab_q   <= stab_d;
         level_q  <= level_d;
         lv_q     <= lv_d;
         fault_q  <= fault_d;
         count_q  <= count_d;
         istart_q <= istart_d;
      end
   end

   assign water_level    = level_q;
   assign level_valid    = lv_q;
   assign probe_fault    = fault_q;
   assign count          = count_q;
   assign interval_start = istart_q;

endmodule

// File: tb/tb_water_level_sampler.sv
// Directed bench for water_level_sampler with SAMPLE_DIV=4, STABLE_N=3, INTERVAL_SAMPLES=5.
module tb_water_level_sampler;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [14:0] probe = 15'h0000;
   logic [3:0]  water_level;
   logic        level_valid;
   logic        probe_fault;
   logic [15:0] count;
   logic        interval_start;

   int checks = 0;
   int failures = 0;
   int exp_count = 0;

   always #5 clk = ~clk;

   water_level_sampler #(
      .SAMPLE_DIV      (4),
      .STABLE_N        (3),
      .INTERVAL_SAMPLES(5),
      .COUNT_W         (16)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .probe         (probe),
      .water_level   (water_level),
      .level_valid   (level_valid),
      .probe_fault   (probe_fault),
      .count         (count),
      .interval_start(interval_start)
   );

   // Called at a negedge with the prescaler at 0; returns at the negedge after the next tick edge.
   task automatic next_tick();
      logic exp_is;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if ({level_valid, probe_fault, interval_start} !== 3'b000) begin
         failures++;
         $display("FAIL pulse_clear: got %b want 000", {level_valid, probe_fault, interval_start});
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      exp_is    = (exp_count == 4);
      exp_count = (exp_count == 4) ? 0 : exp_count + 1;
      checks++;
      if (count !== 16'(exp_count)) begin
         failures++;
         $display("FAIL count: got %0d want %0d", count, exp_count);
      end
      checks++;
      if (interval_start !== exp_is) begin
         failures++;
         $display("FAIL interval_start: got %b want %b", interval_start, exp_is);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      #1;
      checks++;
      if ({water_level, level_valid, probe_fault, count, interval_start} !== 23'd0) begin
         failures++;
         $display("FAIL reset_outputs: level=%0d lv=%b pf=%b count=%0d is=%b want all 0",
                  water_level, level_valid, probe_fault, count, interval_start);
      end
      @(negedge clk);
      @(negedge clk);
      reset     = 1'b0;
      exp_count = 0;
   endtask

   task automatic test_reset();
      probe = 15'h7FFF;
      do_reset();
      for (int t = 1; t <= 3; t++) begin
         next_tick();
         checks++;
         if (level_valid !== (t == 3) || water_level !== ((t == 3) ? 4'd15 : 4'd0)) begin
            failures++;
            $display("FAIL reset_accept t%0d: lv=%b level=%0d want lv=%b level=%0d",
                     t, level_valid, water_level, (t == 3), (t == 3) ? 15 : 0);
         end
      end
   endtask

   task automatic test_glitch();
      logic [14:0] pr[6];
      int          lv[6];
      int          lvl[6];
      pr  = '{15'h00FF, 15'h7FFF, 15'h00FF, 15'h00FF, 15'h00FF, 15'h00FF};
      lv  = '{0, 0, 0, 0, 1, 0};
      lvl = '{15, 15, 15, 15, 8, 8};
      for (int i = 0; i < 6; i++) begin
         probe = pr[i];
         next_tick();
         checks++;
         if (level_valid !== 1'(lv[i]) || water_level !== 4'(lvl[i])) begin
            failures++;
            $display("FAIL glitch t%0d: lv=%b level=%0d want lv=%0d level=%0d",
                     i, level_valid, water_level, lv[i], lvl[i]);
         end
      end
   endtask

   task automatic test_fault();
      logic [14:0] pr[7];
      int          pf[7];
      int          lv[7];
      int          lvl[7];
      pr  = '{15'h003F, 15'h003F, 15'h0005, 15'h0005, 15'h003F, 15'h003F, 15'h003F};
      pf  = '{0, 0, 1, 1, 0, 0, 0};
      lv  = '{0, 0, 0, 0, 0, 0, 1};
      lvl = '{8, 8, 8, 8, 8, 8, 6};
      for (int i = 0; i < 7; i++) begin
         probe = pr[i];
         next_tick();
         checks++;
         if (probe_fault !== 1'(pf[i]) || level_valid !== 1'(lv[i]) ||
             water_level !== 4'(lvl[i])) begin
            failures++;
            $display("FAIL fault t%0d: pf=%b lv=%b level=%0d want pf=%0d lv=%0d level=%0d",
                     i, probe_fault, level_valid, water_level, pf[i], lv[i], lvl[i]);
         end
      end
   endtask

   task automatic test_reset_mid();
      probe = 15'h7FFF;
      for (int i = 0; i < 2; i++) begin
         next_tick();
         checks++;
         if (level_valid !== 1'b0 || water_level !== 4'd6) begin
            failures++;
            $display("FAIL mid_pre t%0d: lv=%b level=%0d want lv=0 level=6",
                     i, level_valid, water_level);
         end
      end
      do_reset();
      for (int t = 1; t <= 3; t++) begin
         next_tick();
         checks++;
         if (level_valid !== (t == 3) || water_level !== ((t == 3) ? 4'd15 : 4'd0)) begin
            failures++;
            $display("FAIL mid_post t%0d: lv=%b level=%0d want lv=%b level=%0d",
                     t, level_valid, water_level, (t == 3), (t == 3) ? 15 : 0);
         end
      end
   endtask

   task automatic test_timebase();
      int cnt[12];
      cnt   = '{1, 2, 3, 4, 0, 1, 2, 3, 4, 0, 1, 2};
      probe = 15'h0000;
      do_reset();
      for (int i = 0; i < 12; i++) begin
         next_tick();
         checks++;
         if (count !== 16'(cnt[i]) || interval_start !== (i == 4 || i == 9) ||
             level_valid !== 1'b0) begin
            failures++;
            $display("FAIL timebase t%0d: count=%0d is=%b lv=%b want count=%0d is=%b lv=0",
                     i + 1, count, interval_start, level_valid, cnt[i], (i == 4 || i == 9));
         end
      end
   endtask

   task automatic test_wrap_accept();
      probe = 15'h01FF;
      next_tick();
      next_tick();
      next_tick();
      checks++;
      if (level_valid !== 1'b1 || interval_start !== 1'b1 || water_level !== 4'd9 ||
          count !== 16'd0) begin
         failures++;
         $display("FAIL wrap_accept: lv=%b is=%b level=%0d count=%0d want lv=1 is=1 level=9 count=0",
                  level_valid, interval_start, water_level, count);
      end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_glitch();
      test_fault();
      test_reset_mid();
      test_timebase();
      test_wrap_accept();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
